// File: rtl/instr_loader.sv
// Boot-time program loader: assembles little-endian words from a byte stream into instruction memory.
// Optional build macro INSTR_LOADER_CHECKSUM_EN treats the last byte as an 8-bit additive checksum.
`timescale 1ns/1ps
module instr_loader #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic              last,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_WC = CNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

  state_t             r_state,      w_state_nxt;
  logic               r_byte_ready, w_byte_ready_nxt;
  logic               r_we,         w_we_nxt;
  logic [ADDR_W-1:0]  r_addr,       w_addr_nxt;
  logic [31:0]        r_wdata,      w_wdata_nxt;
  logic               r_core_hold,  w_core_hold_nxt;
  logic               r_done,       w_done_nxt;
  logic               r_error,      w_error_nxt;
  logic [CNT_W-1:0]   r_wc,         w_wc_nxt;
  logic [1:0]         r_idx,        w_idx_nxt;
  logic [31:0]        r_asm,        w_asm_nxt;

  logic               w_accept;
  logic [31:0]        w_asm_ins;
  logic               w_flush;
  logic               w_finish;
  logic               w_ok;
  logic [31:0]        w_word;

  assign w_accept = byte_valid & r_byte_ready;

  // Assembly register with the incoming byte placed at the current byte lane
  always_comb begin
    w_asm_ins = r_asm;
    w_asm_ins[{r_idx, 3'b000} +: 8] = byte_in;
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] r_sum, w_sum_nxt;

  // Last byte is the checksum: flush any partial word without it and compare sums
  always_comb begin
    w_sum_nxt = r_sum;
    if (w_accept && last) begin
      w_flush  = (r_idx != 2'd0);
      w_word   = r_asm;
      w_finish = 1'b1;
      w_ok     = (byte_in == r_sum);
    end else begin
      w_flush  = (r_idx == 2'd3);
      w_word   = w_asm_ins;
      w_finish = 1'b0;
      w_ok     = 1'b1;
      if (w_accept) w_sum_nxt = r_sum + byte_in;
    end
    if (start && r_state != S_LOAD) w_sum_nxt = 8'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sum <= 8'd0;
    else        r_sum <= w_sum_nxt;
  end
`else
  always_comb begin
    w_flush  = (r_idx == 2'd3) | last;
    w_word   = w_asm_ins;
    w_finish = last;
    w_ok     = 1'b1;
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_byte_ready_nxt = r_byte_ready;
    w_we_nxt         = 1'b0;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_core_hold_nxt  = r_core_hold;
    w_done_nxt       = r_done;
    w_error_nxt      = r_error;
    w_wc_nxt         = r_wc;
    w_idx_nxt        = r_idx;
    w_asm_nxt        = r_asm;

    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          if ((w_flush && r_wc == MAX_WC) || !w_ok) begin
            w_state_nxt      = S_ERR;
            w_error_nxt      = 1'b1;
            w_byte_ready_nxt = 1'b0;
            w_core_hold_nxt  = 1'b1;
          end else begin
            if (w_flush) begin
              w_we_nxt    = 1'b1;
              w_addr_nxt  = r_wc[ADDR_W-1:0];
              w_wdata_nxt = w_word;
              w_wc_nxt    = r_wc + CNT_W'(1);
              w_idx_nxt   = 2'd0;
              w_asm_nxt   = 32'd0;
            end else begin
              w_idx_nxt   = r_idx + 2'd1;
              w_asm_nxt   = w_asm_ins;
            end
            if (w_finish) begin
              w_state_nxt      = S_DONE;
              w_done_nxt       = 1'b1;
              w_core_hold_nxt  = 1'b0;
              w_byte_ready_nxt = 1'b0;
            end
          end
        end
      end
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_state_nxt      = S_LOAD;
          w_byte_ready_nxt = 1'b1;
          w_core_hold_nxt  = 1'b1;
          w_done_nxt       = 1'b0;
          w_error_nxt      = 1'b0;
          w_wc_nxt         = '0;
          w_idx_nxt        = 2'd0;
          w_asm_nxt        = 32'd0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_core_hold  <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_wc         <= '0;
      r_idx        <= 2'd0;
      r_asm        <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_byte_ready <= w_byte_ready_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_core_hold  <= w_core_hold_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
      r_wc         <= w_wc_nxt;
      r_idx        <= w_idx_nxt;
      r_asm        <= w_asm_nxt;
    end
  end

  assign byte_ready = r_byte_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_hold  = r_core_hold;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_wc;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader (MAX_WORDS=2 so the overflow path is reachable quickly).
`timescale 1ns/1ps
module tb_instr_loader;

  localparam int unsigned ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              last;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  instr_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .last(last), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (reset === 1'b1 && imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.data) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   imem_addr, imem_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_wr(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = ADDR_W'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    last       = l;
    while (byte_ready !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    if (byte_ready !== 1'b1) begin
      chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
    end else begin
      tick(1);
    end
    byte_valid = 1'b0;
    last       = 1'b0;
  endtask

  task automatic send_prog1();
    logic [7:0] p [8];
    p = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    expect_wr(0, 32'h0050_0013);
    expect_wr(1, 32'h00A0_0093);
    for (int i = 0; i < 8; i++) send(p[i], i == 7);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; last = 1'b0;
    tick(3);
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_imem_we",    32'(imem_we),    32'd0);
    chk("rst_imem_addr",  32'(imem_addr),  32'd0);
    chk("rst_imem_wdata", imem_wdata,      32'd0);
    chk("rst_core_hold",  32'(core_hold),  32'd1);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_error",      32'(error),      32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    reset = 1'b1;
    tick(2);
    chk("idle_byte_ready", 32'(byte_ready), 32'd0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Good checksum
    pulse_start();
    expect_wr(0, 32'h0403_0201);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    send(8'h0A, 1'b1);
    chk("cs_ok_done",      32'(done),       32'd1);
    chk("cs_ok_core_hold", 32'(core_hold),  32'd0);
    chk("cs_ok_wc",        32'(word_count), 32'd1);
    // Bad checksum
    pulse_start();
    expect_wr(0, 32'h0403_0201);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    send(8'h0B, 1'b1);
    chk("cs_bad_error",     32'(error),     32'd1);
    chk("cs_bad_core_hold", 32'(core_hold), 32'd1);
    chk("cs_bad_done",      32'(done),      32'd0);
    // Partial word flushed by checksum byte
    pulse_start();
    chk("cs_restart_error", 32'(error), 32'd0);
    expect_wr(0, 32'h0003_0201);
    for (int i = 1; i <= 3; i++) send(8'(i), 1'b0);
    send(8'h06, 1'b1);
    tick(1);
    chk("cs_part_done", 32'(done),       32'd1);
    chk("cs_part_wc",   32'(word_count), 32'd1);
`else
    // Two full words
    pulse_start();
    chk("load_core_hold", 32'(core_hold),  32'd1);
    chk("load_ready",     32'(byte_ready), 32'd1);
    send_prog1();
    chk("p1_done",       32'(done),       32'd1);
    chk("p1_core_hold",  32'(core_hold),  32'd0);
    chk("p1_wc",         32'(word_count), 32'd2);
    chk("p1_byte_ready", 32'(byte_ready), 32'd0);
    tick(2);
    chk("p1_wc_hold", 32'(word_count), 32'd2);

    // Zero-padded partial last word, restarted from DONE
    pulse_start();
    chk("p2_done_clr",  32'(done),       32'd0);
    chk("p2_hold_set",  32'(core_hold),  32'd1);
    chk("p2_wc_clr",    32'(word_count), 32'd0);
    expect_wr(0, 32'h0403_0201);
    expect_wr(1, 32'h0000_0605);
    for (int i = 1; i <= 6; i++) send(8'(i), i == 6);
    chk("p2_done", 32'(done),       32'd1);
    chk("p2_wc",   32'(word_count), 32'd2);

    // Gapped byte_valid
    pulse_start();
    expect_wr(0, 32'hDDCC_BBAA);
    expect_wr(1, 32'h0000_0011);
    begin
      logic [7:0] g [5];
      g = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
      for (int i = 0; i < 5; i++) begin
        send(g[i], i == 4);
        tick(2);
      end
    end
    chk("gap_done", 32'(done),       32'd1);
    chk("gap_wc",   32'(word_count), 32'd2);

    // Overflow: third word completes with word_count at capacity
    pulse_start();
    expect_wr(0, 32'h0302_0100);
    expect_wr(1, 32'h0706_0504);
    for (int i = 0; i < 12; i++) send(8'(i), i == 11);
    chk("ovf_error",      32'(error),      32'd1);
    chk("ovf_core_hold",  32'(core_hold),  32'd1);
    chk("ovf_byte_ready", 32'(byte_ready), 32'd0);
    chk("ovf_done",       32'(done),       32'd0);
    chk("ovf_wc",         32'(word_count), 32'd2);
    tick(3);
    chk("ovf_sticky", 32'(error), 32'd1);
    pulse_start();
    chk("ovf_clr_error", 32'(error),      32'd0);
    chk("ovf_clr_wc",    32'(word_count), 32'd0);
    chk("ovf_clr_ready", 32'(byte_ready), 32'd1);
    expect_wr(0, 32'h0000_005A);
    send(8'h5A, 1'b1);
    chk("ovf_reload_done", 32'(done), 32'd1);

    // Reset in the middle of a load
    pulse_start();
    expect_wr(0, 32'h1312_1110);
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rst_wc",    32'(word_count), 32'd0);
    chk("mid_rst_hold",  32'(core_hold),  32'd1);
    chk("mid_rst_ready", 32'(byte_ready), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(1);
    pulse_start();
    send_prog1();
    chk("mid_rst_reload_done", 32'(done),       32'd1);
    chk("mid_rst_reload_wc",   32'(word_count), 32'd2);
`endif

    tick(3);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
